// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared state encoding, segment table constants and widths for the 7-segment decoder
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_DECODE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DIGIT_W   = 8;
    localparam int ERR_CNT_W = 8;
    localparam int CNT_W     = 4;

    // Active-low segment patterns ordered g,f,e,d,c,b,a (MSB = g)
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg7_if.sv
// rtl/seg7_if.sv - request/result bundle between a segment source and the decoder
interface seg7_if;
    import seg7_pkg::*;

    logic                 EN;
    logic [0:7]           DATA_IN;
    logic [0:DIGIT_W-1]   DATA_OUT;
    logic                 DP;
    logic                 VALID;
    logic                 ERR;
    logic [ERR_CNT_W-1:0] ERR_CNT;
    logic                 WAIT;

    modport master (
        output EN, DATA_IN,
        input  DATA_OUT, DP, VALID, ERR, ERR_CNT, WAIT
    );

    modport slave (
        input  EN, DATA_IN,
        output DATA_OUT, DP, VALID, ERR, ERR_CNT, WAIT
    );

endinterface

// File: rtl/seg7_lut.sv
// rtl/seg7_lut.sv - combinational segment-pattern to digit lookup
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       match
);

    always_comb begin
        digit = 4'd0;
        match = 1'b1;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - debounced active-low 7-segment pattern decoder with error counting
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic   CLK,
    input  logic   RST,
    seg7_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    state_t               state_q, state_d;
    logic [0:7]           hold_q, hold_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [0:DIGIT_W-1]   data_out_q, data_out_d;
    logic                 dp_q, dp_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 wait_q, wait_d;

    logic [3:0]           lut_digit;
    logic                 lut_match;

    seg7_lut u_lut (
        .pattern (hold_q[1:7]),
        .digit   (lut_digit),
        .match   (lut_match)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        dp_d       = dp_q;
        valid_d    = valid_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        wait_d     = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.EN) begin
                    hold_d  = bus.DATA_IN;
                    cnt_d   = 4'd1;
                    wait_d  = 1'b1;
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (!bus.EN) begin
                    wait_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    // Hold is frozen here so the decoded pattern is the one that proved stable
                    state_d = ST_DECODE;
                end else if (bus.DATA_IN == hold_q) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    hold_d = bus.DATA_IN;
                    cnt_d  = 4'd1;
                end
            end
            ST_DECODE: begin
                wait_d = 1'b0;
                if (!bus.EN) begin
                    state_d = ST_IDLE;
                end else begin
                    dp_d    = ~hold_q[0];
                    state_d = ST_DONE;
                    if (lut_match) begin
                        data_out_d = DIGIT_W'(lut_digit);
                        valid_d    = 1'b1;
                        err_d      = 1'b0;
                    end else begin
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                        if (err_cnt_q != '1)
                            err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!bus.EN)
                    state_d = ST_IDLE;
            end
            default: begin
                wait_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            hold_q     <= 8'hFF;
            cnt_q      <= '0;
            data_out_q <= '0;
            dp_q       <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            wait_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            dp_q       <= dp_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            wait_q     <= wait_d;
        end
    end

    assign bus.DATA_OUT = data_out_q;
    assign bus.DP       = dp_q;
    assign bus.VALID    = valid_q;
    assign bus.ERR      = err_q;
    assign bus.ERR_CNT  = err_cnt_q;
    assign bus.WAIT     = wait_q;

endmodule
